// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants and MEM->WB bus layout for the write-back stage.
// Holds the bus width, field offsets, RDCNT select codes, CSR_TID and ECODE/ESUBCODE values.
package wb_stage_pkg;
    localparam int WS_BUS_WIDTH = 201;
    localparam int CSR_RE_LSB = 0;
    localparam int CSR_WVALUE_LSB = 1;
    localparam int CSR_WMASK_LSB = 33;
    localparam int CSR_NUM_LSB = 65;
    localparam int CSR_WE_LSB = 79;
    localparam int ERTN_LSB = 80;
    localparam int VADDR_LSB = 81;
    localparam int ESUBCODE_LSB = 113;
    localparam int ECODE_LSB = 122;
    localparam int EX_LSB = 128;
    localparam int RDCNT_LSB = 129;
    localparam int GR_WE_LSB = 131;
    localparam int DEST_LSB = 132;
    localparam int RESULT_LSB = 137;
    localparam int PC_LSB = 169;
    localparam logic [1:0] RDCNT_NONE = 2'b00;
    localparam logic [1:0] RDCNT_VL = 2'b01;
    localparam logic [1:0] RDCNT_VH = 2'b10;
    localparam logic [1:0] RDCNT_ID = 2'b11;
    localparam logic [13:0] CSR_TID = 14'h40;
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;
    // MSB-first view of the bus; csr_re sits at bit 0, pc at the top
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [1:0]  rdcnt_sel;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        csr_re;
    } ws_bus_t;
endpackage

// File: rtl/wb_stage_stable_counter.sv
// stable_counter: 64-bit free-running counter, sync active-high reset.
// Ports: clk, reset in; cnt[63:0] out.
module stable_counter (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] cnt
);
    logic [63:0] r_cnt;
    always_ff @(posedge clk) r_cnt <= reset ? 64'd0 : r_cnt + 64'd1;
    assign cnt = r_cnt;
endmodule

// File: rtl/wb_stage.sv
// wb_stage: LoongArch write-back stage; retires GR/CSR writes, reports exceptions/ERTN, drives pipeline flush.
// Ports: clk/reset; ms_to_ws_valid/bus in, ws_allowin out; CSR access (csr_num/we/wmask/wvalue out, csr_rvalue in);
//        exception report (wb_ex/ecode/esubcode/vaddr/pc, ertn_flush) out, ex_entry/ertn_entry in;
//        ws_flush/flush_target out; rf_we/waddr/wdata and ws_fwd_bus out; ws_csr_hazard out.
// DEBUG_TRACE_EN adds debug_wb_pc/rf_we/rf_wnum/rf_wdata trace ports.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int WS_BUS_W = WS_BUS_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ms_to_ws_valid,
    input  logic [WS_BUS_W-1:0] ms_to_ws_bus,
    output logic                ws_allowin,
    output logic [13:0]         csr_num,
    output logic                csr_we,
    output logic [31:0]         csr_wmask,
    output logic [31:0]         csr_wvalue,
    input  logic [31:0]         csr_rvalue,
    output logic                wb_ex,
    output logic [5:0]          wb_ecode,
    output logic [8:0]          wb_esubcode,
    output logic [31:0]         wb_vaddr,
    output logic [31:0]         wb_pc,
    output logic                ertn_flush,
    input  logic [31:0]         ex_entry,
    input  logic [31:0]         ertn_entry,
    output logic                ws_flush,
    output logic [31:0]         flush_target,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic [37:0]         ws_fwd_bus,
`ifdef DEBUG_TRACE_EN
    output logic [31:0]         debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [4:0]          debug_wb_rf_wnum,
    output logic [31:0]         debug_wb_rf_wdata,
`endif
    output logic                ws_csr_hazard
);
    ws_bus_t     r_bus;
    logic        r_valid;
    logic [63:0] w_cnt;
    logic        w_ready_go;

    stable_counter u_cnt (
        .clk   (clk),
        .reset (reset),
        .cnt   (w_cnt)
    );

    assign w_ready_go = 1'b1;
    assign ws_allowin = !r_valid || w_ready_go;

    // a flushing instruction kills whatever MEM hands over in the same cycle
    always_ff @(posedge clk) begin
        r_valid <= reset ? 1'b0 : ms_to_ws_valid && !ws_flush;
        if (ms_to_ws_valid && ws_allowin) r_bus <= ws_bus_t'(ms_to_ws_bus);
    end

    assign wb_ex        = r_valid && r_bus.ex;
    assign ertn_flush   = r_valid && r_bus.ertn && !r_bus.ex;
    assign ws_flush     = wb_ex || ertn_flush;
    assign flush_target = wb_ex ? ex_entry : ertn_entry;
    assign wb_ecode     = r_bus.ecode;
    assign wb_esubcode  = r_bus.esubcode;
    assign wb_vaddr     = r_bus.vaddr;
    assign wb_pc        = r_bus.pc;

    // rdcntid reads TID through the regular CSR read path
    assign csr_num    = r_bus.rdcnt_sel == RDCNT_ID ? CSR_TID : r_bus.csr_num;
    assign csr_we     = r_valid && r_bus.csr_we && !r_bus.ex;
    assign csr_wmask  = r_bus.csr_wmask;
    assign csr_wvalue = r_bus.csr_wvalue;

    assign rf_we    = r_valid && r_bus.gr_we && !r_bus.ex;
    assign rf_waddr = r_bus.dest;
    assign rf_wdata = r_bus.rdcnt_sel == RDCNT_VL ? w_cnt[31:0] :
                      r_bus.rdcnt_sel == RDCNT_VH ? w_cnt[63:32] :
                      (r_bus.rdcnt_sel == RDCNT_ID || r_bus.csr_re) ? csr_rvalue : r_bus.result;

    assign ws_fwd_bus    = {rf_we, rf_waddr, rf_wdata};
    assign ws_csr_hazard = r_valid && (r_bus.csr_we || r_bus.ertn);

`ifdef DEBUG_TRACE_EN
    assign debug_wb_pc       = r_bus.pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: randomized self-checking bench for wb_stage against a behavioural model.
module tb_wb_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic [1:0]  rdcnt_sel;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic        csr_re;
    } ins_t;

    logic clk = 0;
    always #5 clk = ~clk;

    logic         reset, ms_to_ws_valid, ws_allowin, csr_we, wb_ex, ertn_flush, ws_flush, rf_we, ws_csr_hazard;
    logic [200:0] ms_to_ws_bus;
    logic [13:0]  csr_num;
    logic [31:0]  csr_wmask, csr_wvalue, csr_rvalue, wb_vaddr, wb_pc, ex_entry, ertn_entry, flush_target, rf_wdata;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [4:0]   rf_waddr;
    logic [37:0]  ws_fwd_bus;
`ifdef DEBUG_TRACE_EN
    logic [31:0]  debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
`endif

    wb_stage u_dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .ws_allowin(ws_allowin), .csr_num(csr_num), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr), .wb_pc(wb_pc), .ertn_flush(ertn_flush),
        .ex_entry(ex_entry), .ertn_entry(ertn_entry), .ws_flush(ws_flush), .flush_target(flush_target),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_bus(ws_fwd_bus),
`ifdef DEBUG_TRACE_EN
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
`endif
        .ws_csr_hazard(ws_csr_hazard)
    );

    // tiny CSR file: SAVE0 reads 0x11, everything else a number-derived pattern
    function automatic logic [31:0] csr_model(logic [13:0] n);
        return n == 14'h30 ? 32'h11 : {18'h0, n} ^ 32'hC0DE_0000;
    endfunction
    always_comb csr_rvalue = csr_model(csr_num);

    int errors = 0, checks = 0;
    ins_t m, cur_i, t;
    logic m_valid, m_flush, cur_v, cur_r;
    logic [63:0] m_cnt;

    function automatic logic [200:0] pack(ins_t i);
        return {i.pc, i.result, i.dest, i.gr_we, i.rdcnt_sel, i.ex, i.ecode, i.esubcode, i.vaddr,
                i.ertn, i.csr_we, i.csr_num, i.csr_wmask, i.csr_wvalue, i.csr_re};
    endfunction

    function automatic ins_t blank();
        ins_t i;
        i.pc = 0; i.result = 0; i.dest = 0; i.gr_we = 0; i.rdcnt_sel = 0; i.ex = 0; i.ecode = 0;
        i.esubcode = 0; i.vaddr = 0; i.ertn = 0; i.csr_we = 0; i.csr_num = 0; i.csr_wmask = 0;
        i.csr_wvalue = 0; i.csr_re = 0;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.pc = $urandom; i.result = $urandom; i.dest = 5'($urandom); i.gr_we = 1'($urandom);
        i.rdcnt_sel = $urandom_range(0, 1) == 0 ? 2'b00 : 2'($urandom);
        i.ex = $urandom_range(0, 7) == 0; i.ecode = 6'($urandom); i.esubcode = 9'($urandom);
        i.vaddr = $urandom; i.ertn = $urandom_range(0, 7) == 0; i.csr_we = $urandom_range(0, 3) == 0;
        i.csr_num = $urandom_range(0, 3) == 0 ? 14'h30 : 14'($urandom); i.csr_wmask = $urandom;
        i.csr_wvalue = $urandom; i.csr_re = $urandom_range(0, 3) == 0;
        return i;
    endfunction

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    // model view: the retiring instruction is whatever MEM handed over last, counter = edges since reset
    task automatic compare();
        logic ex_e, ertn_e, rf_e, csr_e;
        logic [13:0] num_e;
        logic [31:0] data_e;
        ex_e = m_valid && m.ex;
        ertn_e = m_valid && m.ertn && !m.ex;
        rf_e = m_valid && m.gr_we && !m.ex;
        csr_e = m_valid && m.csr_we && !m.ex;
        m_flush = ex_e || ertn_e;
        chk("allowin", ws_allowin, 1);
        chk("wb_ex", wb_ex, ex_e);
        chk("ertn_flush", ertn_flush, ertn_e);
        chk("ws_flush", ws_flush, m_flush);
        chk("rf_we", rf_we, rf_e);
        chk("csr_we", csr_we, csr_e);
        chk("csr_hazard", ws_csr_hazard, m_valid && (m.csr_we || m.ertn));
`ifdef DEBUG_TRACE_EN
        chk("dbg_rf_we", debug_wb_rf_we, {4{rf_e}});
`endif
        if (m_valid) begin
            num_e = m.rdcnt_sel == 2'b11 ? 14'h40 : m.csr_num;
            if (m.rdcnt_sel == 2'b01) data_e = m_cnt[31:0];
            else if (m.rdcnt_sel == 2'b10) data_e = m_cnt[63:32];
            else if (m.rdcnt_sel == 2'b11 || m.csr_re) data_e = csr_model(num_e);
            else data_e = m.result;
            chk("csr_num", csr_num, num_e);
            chk("csr_wmask", csr_wmask, m.csr_wmask);
            chk("csr_wvalue", csr_wvalue, m.csr_wvalue);
            chk("wb_ecode", wb_ecode, m.ecode);
            chk("wb_esubcode", wb_esubcode, m.esubcode);
            chk("wb_vaddr", wb_vaddr, m.vaddr);
            chk("wb_pc", wb_pc, m.pc);
            chk("rf_waddr", rf_waddr, m.dest);
            chk("rf_wdata", rf_wdata, data_e);
            chk("fwd_bus", ws_fwd_bus, {rf_e, m.dest, data_e});
            if (m_flush) chk("flush_target", flush_target, ex_e ? ex_entry : ertn_entry);
`ifdef DEBUG_TRACE_EN
            chk("dbg_pc", debug_wb_pc, m.pc);
            chk("dbg_wnum", debug_wb_rf_wnum, m.dest);
            chk("dbg_wdata", debug_wb_rf_wdata, data_e);
`endif
        end
    endtask

    task automatic drive(ins_t i, logic v, logic r, bit frc = 0);
        @(negedge clk);
        reset = r;
        ms_to_ws_valid = v;
        ms_to_ws_bus = pack(i);
        if (frc) begin
            force u_dut.u_cnt.r_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            release u_dut.u_cnt.r_cnt;
            m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        #1;
        compare();
        cur_i = i;
        cur_v = v;
        cur_r = r;
    endtask

    task automatic commit();
        if (cur_v) m = cur_i;
        m_valid = !cur_r && cur_v && !m_flush;
        m_cnt = cur_r ? 64'd0 : m_cnt + 64'd1;
    endtask

    task automatic cyc(ins_t i, logic v, logic r);
        drive(i, v, r);
        commit();
    endtask

    initial begin
        reset = 1;
        ms_to_ws_valid = 0;
        ms_to_ws_bus = '0;
        ex_entry = 32'h1c00_8000;
        ertn_entry = 32'h1c00_0024;
        repeat (2) @(posedge clk);
        m_valid = 0;
        m_cnt = 0;
        m = blank();
        // reset state, with rdcntvl entering right after reset
        t = blank(); t.rdcnt_sel = 2'b01; t.gr_we = 1; t.dest = 7;
        drive(t, 1, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_ws_flush", ws_flush, 0);
        chk("rst_csr_we", csr_we, 0);
        chk("rst_allowin", ws_allowin, 1);
        commit();
        // ADD
        t = blank(); t.pc = 32'h1c00_0010; t.result = 32'h1234_5678; t.dest = 5; t.gr_we = 1;
        drive(t, 1, 0);
        chk("rdcntvl_n", rf_wdata, 32'd1);
        commit();
        drive(blank(), 0, 0);
        chk("add_rf_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 5);
        chk("add_wdata", rf_wdata, 32'h1234_5678);
        chk("add_flush", ws_flush, 0);
        commit();
        // SYS with gr_we, plus a MEM valid in the same cycle
        t = blank(); t.pc = 32'h1c00_0020; t.ex = 1; t.ecode = 6'h0B; t.gr_we = 1; t.dest = 3;
        cyc(t, 1, 0);
        ex_entry = 32'h1c00_8000;
        t = blank(); t.pc = 32'h1c00_0024; t.gr_we = 1; t.dest = 9; t.result = 32'hDEAD_BEEF;
        drive(t, 1, 0);
        chk("sys_wb_ex", wb_ex, 1);
        chk("sys_rf_we", rf_we, 0);
        chk("sys_flush", ws_flush, 1);
        chk("sys_target", flush_target, 32'h1c00_8000);
        chk("sys_ecode", wb_ecode, 6'h0B);
        chk("sys_pc", wb_pc, 32'h1c00_0020);
        commit();
        drive(blank(), 0, 0);
        chk("sys_drop_rf_we", rf_we, 0);
        chk("sys_drop_flush", ws_flush, 0);
        commit();
        // ERTN
        t = blank(); t.ertn = 1; t.pc = 32'h1c00_0030;
        cyc(t, 1, 0);
        ertn_entry = 32'h1c00_0024;
        drive(blank(), 0, 0);
        chk("ertn_flush", ertn_flush, 1);
        chk("ertn_target", flush_target, 32'h1c00_0024);
        chk("ertn_csr_we", csr_we, 0);
        commit();
        // ex together with ertn
        t = blank(); t.ertn = 1; t.ex = 1; t.ecode = 6'h0D;
        cyc(t, 1, 0);
        drive(blank(), 0, 0);
        chk("exertn_ertn", ertn_flush, 0);
        chk("exertn_ex", wb_ex, 1);
        chk("exertn_target", flush_target, ex_entry);
        commit();
        // csrwr SAVE0 with read-back
        t = blank(); t.csr_we = 1; t.csr_num = 14'h30; t.csr_wmask = 32'hFFFF_FFFF;
        t.csr_wvalue = 32'hA5A5_A5A5; t.csr_re = 1; t.gr_we = 1; t.dest = 4;
        cyc(t, 1, 0);
        drive(blank(), 0, 0);
        chk("csrwr_we", csr_we, 1);
        chk("csrwr_num", csr_num, 14'h30);
        chk("csrwr_rdata", rf_wdata, 32'h11);
        chk("csrwr_hazard", ws_csr_hazard, 1);
        chk("csrwr_wvalue", csr_wvalue, 32'hA5A5_A5A5);
        commit();
        // exception suppresses the CSR write
        t.ex = 1; t.ecode = 6'h09;
        cyc(t, 1, 0);
        drive(blank(), 0, 0);
        chk("excsr_we", csr_we, 0);
        chk("excsr_rf_we", rf_we, 0);
        commit();
        // counter wrap then rdcntvh, then rdcntid
        t = blank(); t.rdcnt_sel = 2'b10; t.gr_we = 1; t.dest = 8;
        drive(t, 1, 0, 1);
        commit();
        t = blank(); t.rdcnt_sel = 2'b11; t.gr_we = 1; t.dest = 9;
        drive(t, 1, 0);
        chk("wrap_vh", rf_wdata, 32'd0);
        commit();
        drive(blank(), 0, 0);
        chk("rdcntid_num", csr_num, 14'h40);
        commit();
        // reset while an instruction is in WB
        t = blank(); t.gr_we = 1; t.dest = 2; t.result = 32'h55;
        cyc(t, 1, 0);
        drive(t, 1, 1);
        commit();
        t = blank(); t.rdcnt_sel = 2'b01; t.gr_we = 1; t.dest = 1;
        drive(t, 1, 0);
        chk("rstmid_rf_we", rf_we, 0);
        chk("rstmid_flush", ws_flush, 0);
        commit();
        drive(blank(), 0, 0);
        chk("rstmid_cnt", rf_wdata, 32'd1);
        commit();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            ex_entry = $urandom;
            ertn_entry = $urandom;
            cyc(rand_ins(), $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
